// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_t;

    // Attributes of the granted transaction needed to form its response.
    typedef struct packed {
        arb_owner_t owner;
        logic       we;
        logic       err;
    } arb_txn_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata, d_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata, d_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: data priority, fetch wins once the data streak hits its cap.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic             if_req_i,
    input  logic             d_req_i,
    input  logic [CNT_W-1:0] streak_i,
    output logic             grant_valid_o,
    output arb_owner_t       grant_owner_o
);

    always_comb begin
        grant_valid_o = if_req_i | d_req_i;
        grant_owner_o = OWN_D;
        if (if_req_i && (!d_req_i || (streak_i == CNT_W'(MAX_DATA_STREAK)))) begin
            grant_owner_o = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one big-endian 32-bit-word memory between instruction fetch and data load/store.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MEM_LATENCY     = 1,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  streak_q, streak_d;
    arb_txn_t          txn_q, txn_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              if_ready_q, if_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;

    logic              grant_valid;
    arb_owner_t        grant_owner;
    logic              d_misaligned;

    mem_arb_pick #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_pick (
        .if_req_i      (bus.if_req),
        .d_req_i       (bus.d_req),
        .streak_i      (streak_q),
        .grant_valid_o (grant_valid),
        .grant_owner_o (grant_owner)
    );

    assign d_misaligned = (bus.d_addr[1:0] != 2'b00);

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        txn_d       = txn_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_ready_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d     = ACCESS;
                    cnt_d       = CNT_W'(MEM_LATENCY - 1);
                    txn_d.owner = grant_owner;
                    if (grant_owner == OWN_D) begin
                        txn_d.we    = bus.d_we;
                        txn_d.err   = d_misaligned;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        mem_we_d    = bus.d_we & ~d_misaligned;
                        // Streak only counts data wins that kept fetch waiting.
                        if (!bus.if_req) begin
                            streak_d = '0;
                        end else if (streak_q != CNT_W'(MAX_DATA_STREAK)) begin
                            streak_d = streak_q + CNT_W'(1);
                        end
                    end else begin
                        txn_d.we   = 1'b0;
                        txn_d.err  = 1'b0;
                        mem_addr_d = bus.if_addr;
                        streak_d   = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (txn_q.owner == OWN_IF) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        d_err_d   = txn_q.err;
                        d_rdata_d = (txn_q.we || txn_q.err) ? '0 : bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            txn_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            txn_q       <= txn_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            if_ready_q  <= if_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_ready_q   <= d_ready_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;

endmodule
